// File: rtl/trace_pkg.sv
// Shared types for the retirement trace buffer: event kind, record layout and its width.
// The packed record is {kind, idx, data, pc, stamp}, with kind in the MSB.
package trace_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_STAMP_W = 16;

    typedef enum logic {
        KIND_REG   = 1'b0,
        KIND_STORE = 1'b1
    } kind_e;

    typedef struct packed {
        kind_e                  kind;
        logic [DEF_PC_W-1:0]    idx;
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_STAMP_W-1:0] stamp;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // Same field order as trace_rec_t, for non-default widths.
    function automatic int rec_width(input int data_w, input int pc_w, input int stamp_w);
        return 1 + pc_w + data_w + pc_w + stamp_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: DEPTH x W flops with two write ports and one asynchronous read port.
// Both write addresses are distinct whenever both enables are set (tail and tail+1).
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [W-1:0]  data0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [W-1:0]  data1_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        // NOTE: start from the held value so every path assigns mem_d; no latch is inferred.
        mem_d = mem_q;
        if (we0_i) mem_d[addr0_i] = data0_i;
        if (we1_i) mem_d[addr1_i] = data1_i;
    end

    // NOTE: the array has no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer: captures WB register writes and MEM stores with a cycle stamp
// into a circular buffer drained through a show-ahead valid/ready port.
import trace_pkg::*;

module wb_trace_buffer #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    parameter int DROP_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     mode_wrap_i,
    input  logic                     freeze_i,
    input  logic                     wb_valid_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic [PC_W-1:0]          wb_pc_i,
    input  logic                     st_valid_i,
    input  logic [PC_W-1:0]          st_addr_i,
    input  logic [DATA_W-1:0]        st_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_kind_o,
    output logic [PC_W-1:0]          out_idx_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [PC_W-1:0]          out_pc_o,
    output logic [STAMP_W-1:0]       out_stamp_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RW    = rec_width(DATA_W, PC_W, STAMP_W);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_q, drop_d;

    logic               push_reg, push_st, pop;
    logic [1:0]         n_push, accepted, overwritten, dropped;
    logic [CNT_W-1:0]   avail;
    logic [DROP_W:0]    drop_sum;
    logic [RW-1:0]      reg_rec, st_rec, wr0_rec, head_rec;
    logic               we0, we1;

    always_comb begin
        push_reg = !freeze_i && wb_valid_i && (wb_rd_i != 5'd0);
        push_st  = !freeze_i && st_valid_i;
        n_push   = {1'b0, push_reg} + {1'b0, push_st};
        pop      = (count_q != '0) && out_ready_i;
        avail    = DEPTH_C - count_q + CNT_W'(pop);

        accepted    = n_push;
        overwritten = 2'd0;
        dropped     = 2'd0;
        // avail < n_push <= 2 here, so its low two bits carry the whole value.
        if (CNT_W'(n_push) > avail) begin
            if (mode_wrap_i) begin
                overwritten = n_push - avail[1:0];
            end else begin
                accepted = avail[1:0];
                dropped  = n_push - avail[1:0];
            end
        end

        reg_rec = {1'(KIND_REG), PC_W'(wb_rd_i), wb_data_i, wb_pc_i, stamp_q};
        st_rec  = {1'(KIND_STORE), st_addr_i, st_data_i, {PC_W{1'b0}}, stamp_q};
        wr0_rec = push_reg ? reg_rec : st_rec;
        we0     = !clr_i && (accepted != 2'd0);
        we1     = !clr_i && (accepted == 2'd2);

        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(dropped);

        stamp_d    = stamp_q + 1'b1;
        head_d     = head_q + PTR_W'(pop) + PTR_W'(overwritten);
        tail_d     = tail_q + PTR_W'(accepted);
        count_d    = count_q - CNT_W'(pop) + CNT_W'(accepted) - CNT_W'(overwritten);
        overflow_d = overflow_q || (overwritten != 2'd0);
        drop_d     = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[DROP_W-1:0];

        if (clr_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            stamp_q    <= stamp_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk_i   (clk_i),
        .we0_i   (we0),
        .addr0_i (tail_q),
        .data0_i (wr0_rec),
        .we1_i   (we1),
        .addr1_i (tail_q + PTR_W'(1)),
        .data1_i (st_rec),
        .raddr_i (head_q),
        .rdata_o (head_rec)
    );

    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_q;

    always_comb begin
        {out_kind_o, out_idx_o, out_data_o, out_pc_o, out_stamp_o} = out_valid_o ? head_rec : '0;
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer (DEPTH=4): hand-computed vector table plus a
// queue scoreboard holding the expected buffer contents, checked every cycle.
import trace_pkg::*;

module tb_wb_trace_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i, clr_i, mode_wrap_i, freeze_i;
    logic        wb_valid_i, st_valid_i, out_ready_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i, wb_pc_i, st_addr_i, st_data_i;
    logic        out_valid_o, out_kind_o, overflow_o;
    logic [31:0] out_idx_o, out_data_o, out_pc_o;
    logic [15:0] out_stamp_o;
    logic [2:0]  count_o;
    logic [7:0]  drop_cnt_o;

    wb_trace_buffer #(
        .DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .STAMP_W(16), .DROP_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .mode_wrap_i(mode_wrap_i),
        .freeze_i(freeze_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .wb_pc_i(wb_pc_i), .st_valid_i(st_valid_i),
        .st_addr_i(st_addr_i), .st_data_i(st_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_kind_o(out_kind_o), .out_idx_o(out_idx_o),
        .out_data_o(out_data_o), .out_pc_o(out_pc_o), .out_stamp_o(out_stamp_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    trace_rec_t  exp_q[$];
    logic [15:0] m_stamp;
    logic        m_ovf;
    logic [7:0]  m_drop;

    typedef struct {
        bit          wrap, freeze, clr, ready, wbv, stv;
        logic [4:0]  rd;
        logic [31:0] wdata, pc, saddr, sdata;
        int          exp_count;
        bit          exp_ovf;
        int          exp_drop;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wrap, input bit freeze, input bit clr, input bit ready,
                                input bit wbv, input logic [4:0] rd, input logic [31:0] wdata,
                                input logic [31:0] pc, input bit stv, input logic [31:0] saddr,
                                input logic [31:0] sdata, input int cnt, input bit ovf,
                                input int drop);
        vec_t v;
        v.wrap = wrap; v.freeze = freeze; v.clr = clr; v.ready = ready;
        v.wbv = wbv; v.rd = rd; v.wdata = wdata; v.pc = pc;
        v.stv = stv; v.saddr = saddr; v.sdata = sdata;
        v.exp_count = cnt; v.exp_ovf = ovf; v.exp_drop = drop;
        return v;
    endfunction

    task automatic model_push(input trace_rec_t r);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(r);
        end else if (mode_wrap_i) begin
            void'(exp_q.pop_front());
            exp_q.push_back(r);
            m_ovf = 1'b1;
        end else if (m_drop != 8'hff) begin
            m_drop++;
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, " valid"}, 64'(out_valid_o), 64'(exp_q.size() != 0));
        check({tag, " count"}, 64'(count_o), 64'(exp_q.size()));
        check({tag, " overflow"}, 64'(overflow_o), 64'(m_ovf));
        check({tag, " drop"}, 64'(drop_cnt_o), 64'(m_drop));
        if (exp_q.size() != 0) begin
            check({tag, " kind"}, 64'(out_kind_o), 64'(exp_q[0].kind));
            check({tag, " idx"}, 64'(out_idx_o), 64'(exp_q[0].idx));
            check({tag, " data"}, 64'(out_data_o), 64'(exp_q[0].data));
            check({tag, " pc"}, 64'(out_pc_o), 64'(exp_q[0].pc));
            check({tag, " stamp"}, 64'(out_stamp_o), 64'(exp_q[0].stamp));
        end else begin
            check({tag, " idle zero"}, {out_idx_o, out_data_o}, 64'h0);
        end
    endtask

    // Update the scoreboard from the inputs as they stand, clock once, then compare.
    task automatic step(input string tag);
        trace_rec_t r;
        if (clr_i) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_drop = 8'h0;
        end else begin
            if (out_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
            if (!freeze_i && wb_valid_i && wb_rd_i != 5'd0) begin
                r.kind = KIND_REG; r.idx = {27'h0, wb_rd_i}; r.data = wb_data_i;
                r.pc = wb_pc_i; r.stamp = m_stamp;
                model_push(r);
            end
            if (!freeze_i && st_valid_i) begin
                r.kind = KIND_STORE; r.idx = st_addr_i; r.data = st_data_i;
                r.pc = 32'h0; r.stamp = m_stamp;
                model_push(r);
            end
        end
        @(posedge clk);
        #1;
        m_stamp++;
        compare_outputs(tag);
    endtask

    task automatic idle_inputs();
        clr_i = 0; freeze_i = 0; wb_valid_i = 0; st_valid_i = 0; out_ready_i = 0;
        wb_rd_i = 0; wb_data_i = 0; wb_pc_i = 0; st_addr_i = 0; st_data_i = 0;
    endtask

    initial begin
        //              wrap frz clr rdy wbv rd  wdata  pc      stv saddr   sdata  cnt ovf drop
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,  0,     0,      0, 0,      0,     0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0,  0,     0,      0, 0,      0,     0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,  0,     0,      0, 0,      0,     0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 8,  5,     'h10,   0, 0,      0,     1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 1, 9,  7,     'h14,   1, 'h20,   7,     2, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 0, 0,  0,     0,      0, 0,      0,     1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0,  0,     0,      0, 0,      0,     0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0,  'h55,  'h18,   0, 0,      0,     0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1,  'h11,  'h100,  0, 0,      0,     1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 2,  'h22,  'h104,  0, 0,      0,     2, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 3,  'h33,  'h108,  0, 0,      0,     3, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 4,  'h44,  'h10c,  1, 'h40,   'h99,  4, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 1, 5,  'h66,  'h110,  0, 0,      0,     4, 0, 1);
        vecs[13] = mk(0, 1, 0, 0, 1, 6,  'h77,  'h114,  1, 'h44,   'h1,   4, 0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,  0,     0,      1, 'h48,   'h2,   4, 0, 2);
        vecs[15] = mk(0, 0, 1, 1, 1, 7,  'h88,  'h118,  1, 'h4c,   'h3,   0, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 1, 10, 'ha0,  'h200,  0, 0,      0,     1, 0, 0);
        vecs[17] = mk(1, 0, 0, 0, 1, 11, 'ha1,  'h204,  0, 0,      0,     2, 0, 0);
        vecs[18] = mk(1, 0, 0, 0, 1, 12, 'ha2,  'h208,  0, 0,      0,     3, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 1, 13, 'ha3,  'h20c,  0, 0,      0,     4, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 1, 14, 'ha4,  'h210,  1, 'h80,   'hb4,  4, 1, 0);
        vecs[21] = mk(1, 0, 1, 0, 0, 0,  0,     0,      0, 0,      0,     0, 0, 0);
        vecs[22] = mk(1, 0, 0, 1, 1, 15, 'hc0,  'h300,  1, 'h90,   'hc1,  2, 0, 0);
        vecs[23] = mk(1, 0, 0, 0, 0, 0,  0,     0,      0, 0,      0,     2, 0, 0);

        idle_inputs();
        mode_wrap_i = 0;
        rst_i       = 1;
        m_stamp = 0; m_ovf = 0; m_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        compare_outputs("reset");
        rst_i = 0;

        foreach (vecs[i]) begin
            mode_wrap_i = vecs[i].wrap; freeze_i = vecs[i].freeze; clr_i = vecs[i].clr;
            out_ready_i = vecs[i].ready; wb_valid_i = vecs[i].wbv; wb_rd_i = vecs[i].rd;
            wb_data_i = vecs[i].wdata; wb_pc_i = vecs[i].pc; st_valid_i = vecs[i].stv;
            st_addr_i = vecs[i].saddr; st_data_i = vecs[i].sdata;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl count", i), 64'(count_o), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d tbl valid", i), 64'(out_valid_o), 64'(vecs[i].exp_count != 0));
            check($sformatf("vec%0d tbl ovf", i), 64'(overflow_o), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d tbl drop", i), 64'(drop_cnt_o), 64'(vecs[i].exp_drop));
            if (i == 3) begin
                check("single kind", 64'(out_kind_o), 64'(KIND_REG));
                check("single idx", 64'(out_idx_o), 64'd8);
                check("single data", 64'(out_data_o), 64'd5);
                check("single pc", 64'(out_pc_o), 64'h10);
                check("single stamp", 64'(out_stamp_o), 64'd3);
            end
            if (i == 5) begin
                check("dual store kind", 64'(out_kind_o), 64'(KIND_STORE));
                check("dual store pc", 64'(out_pc_o), 64'h0);
                check("dual store idx", 64'(out_idx_o), 64'h20);
            end
            if (i == 12) check("full pop head stamp", 64'(out_stamp_o), 64'd9);
            if (i == 20) check("wrap head stamp", 64'(out_stamp_o), 64'd18);
        end

        // Asynchronous reset with entries held, no clock edge in between.
        idle_inputs();
        wb_valid_i = 1; wb_rd_i = 20; wb_data_i = 'hd0; wb_pc_i = 'h400;
        step("pre-reset push");
        check("pre-reset count", 64'(count_o), 64'd3);
        idle_inputs();
        #3;
        rst_i = 1;
        #1;
        check("async valid", 64'(out_valid_o), 64'd0);
        check("async count", 64'(count_o), 64'd0);
        exp_q.delete();
        m_stamp = 0; m_ovf = 0; m_drop = 0;
        #1;
        rst_i = 0;
        wb_valid_i = 1; wb_rd_i = 21; wb_data_i = 'he0; wb_pc_i = 'h500;
        step("post-reset push");
        check("post-reset stamp", 64'(out_stamp_o), 64'd0);

        // Randomised run against the scoreboard, toggling mode now and then.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) mode_wrap_i = ~mode_wrap_i;
            clr_i       = ($urandom_range(0, 40) == 0);
            freeze_i    = ($urandom_range(0, 7) == 0);
            out_ready_i = ($urandom_range(0, 9) < 4);
            wb_valid_i  = ($urandom_range(0, 9) < 6);
            wb_rd_i     = 5'($urandom_range(0, 31));
            wb_data_i   = $urandom;
            wb_pc_i     = $urandom;
            st_valid_i  = ($urandom_range(0, 1) == 1);
            st_addr_i   = $urandom;
            st_data_i   = $urandom;
            step($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
